// File: rtl/fp_pkg.sv
// Shared FP32 constants, collector state encoding and an Inf/NaN helper.
// Used by adder_input_collector (optional feature macro: ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN).
package fp_pkg;

  localparam int unsigned DW          = 32;
  localparam int unsigned EXP_HI      = 30;
  localparam int unsigned EXP_LO      = 23;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam logic [DW-1:0] FP_POS_ZERO = 32'h0000_0000;

  typedef logic [DW-1:0] fp32_t;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  // All-ones exponent marks Inf or NaN
  function automatic logic is_inf_nan(input fp32_t w);
    return &w[EXP_HI:EXP_LO];
  endfunction

endpackage

// File: rtl/adder_input_collector_if.sv
// Serial-in / frame-out bus between the stream source, the collector and the adder tree.
// Special_Out exists only with ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN defined.
interface adder_input_collector_if #(
  parameter int unsigned N_CH = 128,
  parameter int unsigned DW   = 32
);

  logic [DW-1:0]      Data_In;
  logic               Valid_In;
  logic               Ready_Out;
  logic               Flush;
  logic [N_CH*DW-1:0] Data_Out;
  logic               Valid_Out;
  logic [15:0]        Frame_Cnt;
`ifdef ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN
  logic               Special_Out;

  modport master (
    output Data_In, Valid_In, Flush,
    input  Ready_Out, Data_Out, Valid_Out, Frame_Cnt, Special_Out
  );

  modport slave (
    input  Data_In, Valid_In, Flush,
    output Ready_Out, Data_Out, Valid_Out, Frame_Cnt, Special_Out
  );
`else
  modport master (
    output Data_In, Valid_In, Flush,
    input  Ready_Out, Data_Out, Valid_Out, Frame_Cnt
  );

  modport slave (
    input  Data_In, Valid_In, Flush,
    output Ready_Out, Data_Out, Valid_Out, Frame_Cnt
  );
`endif

endinterface

// File: rtl/collector_slot_ctrl.sv
// Slot counter, written-mask, COLLECT/EMIT sequencing and frame counter for the collector.
// first_acc_c/emit_nxt_c ports exist only with ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN.
module collector_slot_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned N_CH = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic                          flush,
  output logic                          ready,
  output logic                          valid_out,
  output logic [FRAME_CNT_W-1:0]        frame_cnt,
  output logic                          accept_c,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_idx_c,
  output logic [N_CH-1:0]               mask_nxt_c
`ifdef ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN
  ,
  output logic                          first_acc_c,
  output logic                          emit_nxt_c
`endif
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [N_CH-1:0]        mask_q, mask_d;
  logic                   ready_q, ready_d;
  logic                   valid_q, valid_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   first_c;

  // Next-state: store the word first, then decide whether the frame closes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    frame_cnt_d = frame_cnt_q;
    accept_c    = valid_in && ready_q;
    first_c     = accept_c && (cnt_q == '0);

    case (state_q)
      COLLECT: begin
        if (accept_c) begin
          cnt_d  = cnt_q + CW'(1);
          mask_d = (first_c ? '0 : mask_q) | (N_CH'(1) << cnt_q);
        end
        if ((accept_c && (cnt_q == CW'(N_CH - 1))) ||
            (flush && (accept_c || (cnt_q != '0)))) begin
          state_d     = EMIT;
          cnt_d       = '0;
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
      end
      EMIT:    state_d = COLLECT;
      default: state_d = COLLECT;
    endcase

    ready_d = (state_d == COLLECT);
    valid_d = (state_d == EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      mask_q      <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign ready      = ready_q;
  assign valid_out  = valid_q;
  assign frame_cnt  = frame_cnt_q;
  assign wr_idx_c   = cnt_q;
  assign mask_nxt_c = mask_d;
`ifdef ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN
  assign first_acc_c = first_c;
  assign emit_nxt_c  = valid_d;
`endif

endmodule

// File: rtl/adder_input_collector.sv
// Collects N_CH serial FP32 words into one registered parallel frame for the adder tree.
// Optional Inf/NaN frame flag (Special_Out) with ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN.
module adder_input_collector
  import fp_pkg::*;
#(
  parameter int unsigned N_CH = 128,
  parameter int unsigned DW   = fp_pkg::DW
) (
  input logic                    clk,
  input logic                    rst_n,
  adder_input_collector_if.slave bus
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned FW = N_CH * DW;

  logic            accept_c;
  logic [CW-1:0]   wr_idx_c;
  logic [N_CH-1:0] mask_nxt_c;
  logic [FW-1:0]   frame_q, frame_d;
`ifdef ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN
  logic            first_acc_c;
  logic            emit_nxt_c;
  logic            sticky_q, sticky_d;
  logic            special_q, special_d;
`endif

  collector_slot_ctrl #(.N_CH(N_CH)) u_slot_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (bus.Valid_In),
    .flush      (bus.Flush),
    .ready      (bus.Ready_Out),
    .valid_out  (bus.Valid_Out),
    .frame_cnt  (bus.Frame_Cnt),
    .accept_c   (accept_c),
    .wr_idx_c   (wr_idx_c),
    .mask_nxt_c (mask_nxt_c)
`ifdef ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN
    ,
    .first_acc_c(first_acc_c),
    .emit_nxt_c (emit_nxt_c)
`endif
  );

  // frame_q holds the already-masked image, so unwritten slots read +0.0 straight from flops
  always_comb begin
    frame_d = frame_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!mask_nxt_c[i])
        frame_d[i*DW +: DW] = DW'(FP_POS_ZERO);
      else if (accept_c && (wr_idx_c == CW'(i)))
        frame_d[i*DW +: DW] = bus.Data_In;
      else
        frame_d[i*DW +: DW] = frame_q[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_q <= '0;
    else        frame_q <= frame_d;
  end

  assign bus.Data_Out = frame_q;

`ifdef ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN
  // Sticky Inf/NaN flag restarts on the first word of each frame
  always_comb begin
    sticky_d = sticky_q;
    if (accept_c)
      sticky_d = (first_acc_c ? 1'b0 : sticky_q) | is_inf_nan(bus.Data_In);
    special_d = emit_nxt_c && sticky_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q  <= 1'b0;
      special_q <= 1'b0;
    end else begin
      sticky_q  <= sticky_d;
      special_q <= special_d;
    end
  end

  assign bus.Special_Out = special_q;
`endif

endmodule

// File: tb/tb_adder_input_collector.sv
// Directed scoreboard bench for adder_input_collector (checks Special_Out when
// ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN is defined).
module tb_adder_input_collector;

  localparam int unsigned N_CH = 128;
  localparam int unsigned DW   = 32;
  localparam int unsigned FW   = N_CH * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  adder_input_collector_if #(.N_CH(N_CH), .DW(DW)) bus ();

  adder_input_collector #(.N_CH(N_CH), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [FW-1:0] data;
    logic [15:0]   cnt;
    logic          spec;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [FW-1:0] m_frame;
  int            m_cnt;
  logic [15:0]   m_fcnt;
  logic          m_spec;
  logic          chk_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fp_of_int(input int k);
    int e;
    e = 0;
    while ((k >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((k << (23 - e)) & 32'h007F_FFFF)};
  endfunction

  function automatic exp_t close_frame();
    exp_t e;
    m_fcnt++;
    e.data = m_frame;
    e.cnt  = m_fcnt;
    e.spec = m_spec;
    e.cyc  = cyc + 1;
    m_cnt  = 0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [31:0] w, input logic fl);
    int n;
    bus.Valid_In = 1'b1;
    bus.Data_In  = w;
    bus.Flush    = fl;
    n = 0;
    while (bus.Ready_Out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready wait timeout", 64'(n), 64'(0));
    if (m_cnt == 0) begin
      m_frame = '0;
      m_spec  = 1'b0;
    end
    m_frame[m_cnt*DW +: DW] = w;
    m_spec = m_spec | (w[30:23] == 8'hFF);
    m_cnt++;
    if (m_cnt == N_CH || fl) sb.push_back(close_frame());
    @(posedge clk);
    @(negedge clk);
    bus.Valid_In = 1'b0;
    bus.Flush    = 1'b0;
  endtask

  task automatic flush_only();
    bus.Valid_In = 1'b0;
    bus.Flush    = 1'b1;
    if (m_cnt > 0) sb.push_back(close_frame());
    @(posedge clk);
    @(negedge clk);
    bus.Flush = 1'b0;
  endtask

  // Output monitor: every Valid_Out pulse pops and checks one expected frame
  always @(negedge clk) begin
    if (rst_n && bus.Valid_Out === 1'b1) begin
      chk("unexpected Valid_Out", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("emit cycle", 64'(cyc), 64'(e.cyc));
        chk("Frame_Cnt at emit", 64'(bus.Frame_Cnt), 64'(e.cnt));
        chk("Ready_Out in EMIT", 64'(bus.Ready_Out), 64'd0);
        for (int k = 0; k < N_CH; k++)
          chk($sformatf("Data_Out slot %0d", k + 1),
              64'(bus.Data_Out[k*DW +: DW]), 64'(e.data[k*DW +: DW]));
`ifdef ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN
        chk("Special_Out", 64'(bus.Special_Out), 64'(e.spec));
`endif
      end
    end
    if (rst_n && chk_ready)
      chk("Ready_Out vs Valid_Out", 64'(bus.Ready_Out), 64'(!bus.Valid_Out));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Valid_In = 1'b0;
    bus.Flush    = 1'b0;
    bus.Data_In  = '0;
    m_frame      = '0;
    m_cnt        = 0;
    m_fcnt       = '0;
    m_spec       = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset Valid_Out", 64'(bus.Valid_Out), 64'd0);
    chk("reset Ready_Out", 64'(bus.Ready_Out), 64'd0);
    chk("reset Frame_Cnt", 64'(bus.Frame_Cnt), 64'd0);
    chk("reset Data_Out nonzero", 64'(bus.Data_Out != '0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("Ready_Out after release", 64'(bus.Ready_Out), 64'd1);
    chk_ready = 1'b1;

    // Full frame 1.0 .. 128.0 back-to-back
    for (int k = 1; k <= int'(N_CH); k++) send(fp_of_int(k), 1'b0);
    @(negedge clk);
    chk("single pulse", 64'(bus.Valid_Out), 64'd0);
    repeat (2) @(negedge clk);
    chk("hold slot 128", 64'(bus.Data_Out[FW-1 -: DW]), 64'(fp_of_int(128)));
    chk("hold slot 1", 64'(bus.Data_Out[DW-1:0]), 64'h3F80_0000);

    // Partial frame: five 1.0 words, then Flush
    for (int k = 0; k < 5; k++) send(32'h3F80_0000, 1'b0);
    repeat (2) @(negedge clk);
    flush_only();
    chk("partial slot 5", 64'(bus.Data_Out[5*DW-1 -: DW]), 64'h3F80_0000);
    chk("partial slot 6 zero", 64'(bus.Data_Out[6*DW-1 -: DW]), 64'h0);

    // Flush on an empty buffer is ignored
    repeat (2) @(negedge clk);
    flush_only();
    chk("empty flush Valid_Out", 64'(bus.Valid_Out), 64'd0);
    chk("empty flush Frame_Cnt", 64'(bus.Frame_Cnt), 64'(m_fcnt));

    // Flush held across the EMIT cycle is ignored
    send(32'h4040_0000, 1'b0);
    send(32'h4080_0000, 1'b1);
    flush_only();
    chk("EMIT flush Valid_Out", 64'(bus.Valid_Out), 64'd0);
    chk("EMIT flush Frame_Cnt", 64'(bus.Frame_Cnt), 64'(m_fcnt));

    // Flush coincident with the 3rd accept
    send(32'hC000_0000, 1'b0);
    send(32'h3F00_0000, 1'b0);
    send(32'h4120_0000, 1'b1);
    @(negedge clk);

    // Reset after 60 words discards the partial frame
    for (int k = 1; k <= 60; k++) send(fp_of_int(k), 1'b0);
    chk_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid reset Valid_Out", 64'(bus.Valid_Out), 64'd0);
    chk("mid reset Ready_Out", 64'(bus.Ready_Out), 64'd0);
    chk("mid reset Frame_Cnt", 64'(bus.Frame_Cnt), 64'd0);
    chk("mid reset Data_Out nonzero", 64'(bus.Data_Out != '0), 64'd0);
    m_cnt  = 0;
    m_fcnt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_ready = 1'b1;
    for (int k = 1; k <= int'(N_CH); k++) send(fp_of_int(129 - k), 1'b0);
    @(negedge clk);

    // Inf/NaN flag: frame with a NaN, then a clean frame
    send(32'h3F80_0000, 1'b0);
    send(32'h7FC0_0000, 1'b0);
    send(32'h4000_0000, 1'b1);
    @(negedge clk);
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b1);

    repeat (4) @(negedge clk);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    chk("final Frame_Cnt", 64'(bus.Frame_Cnt), 64'(m_fcnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_input_collector.md
Name: adder_input_collector

Overview:
- Producer side of the 128-input FP32 adder-tree interface.
- Accepts a serial stream of FP32 words over a valid/ready handshake and assembles N_CH words into a packed parallel frame.
- Presents the frame with a one-cycle Valid_Out pulse that drives the adder tree's Valid_In.
- Sits between the per-channel multiplier/stream source and the N-input adder tree.

Parameters:
- N_CH, 128, number of channels per frame; power of two, 2..128.
- DW, 32, word width (IEEE-754 single).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Data_In  input  DW  serial input word; channel order 1..N_CH.
- Valid_In  input  1  Data_In valid.
- Ready_Out  output  1  collector can accept Data_In this cycle.
- Flush  input  1  close the current partial frame; unwritten slots read as +0.0.
- Data_Out  output  N_CH*DW  packed frame; channel k at bits [k*DW-1 -: DW], k=1..N_CH.
- Valid_Out  output  1  one-cycle pulse, frame valid; connects to adder-tree Valid_In.
- Frame_Cnt  output  16  count of emitted frames, wraps 0xFFFF->0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=COLLECT, slot counter=0, written-mask=0, Frame_Cnt=0.
  - Valid_Out=0, Ready_Out=0 while rst_n=0, then 1 from the first cycle after release.
  - Data_Out=0, because the mask is 0.
- Storage: buffer buf[N_CH] of DW bits plus written-mask[N_CH]. Data_Out slot k = mask[k] ? buf[k] : 32'h0, registered, not recomputed combinationally from inputs.
- Accept: a word is accepted when Valid_In && Ready_Out at a rising edge. It writes buf[cnt], sets mask[cnt], and increments cnt.
- States:
  - COLLECT: Ready_Out=1.
    - Accept at cnt=N_CH-1, or Flush=1 with cnt>0, moves to EMIT.
    - Flush with cnt=0 and no accept is ignored; no empty frame is emitted.
  - EMIT (exactly one cycle): Valid_Out=1, Ready_Out=0, Frame_Cnt increments. Next cycle returns to COLLECT with cnt=0.
    - Mask is cleared lazily: on the first accept of the next frame, mask is set to one-hot of slot 0.
    - Data_Out therefore holds the emitted frame until that first accept.
- Latency: last accepted word or Flush at edge t -> Valid_Out=1 during cycle t+1, with Data_Out already updated. Peak throughput is N_CH words per N_CH+1 cycles.
- Simultaneous Flush and accept in COLLECT: the word is stored first, then the frame closes. The word counts as part of the frame.
- Flush during EMIT: ignored.
- Valid_In during EMIT: not accepted; the source must hold the word (Ready_Out=0).
- Reset mid-frame: the partial frame is discarded; no Valid_Out is generated.
- Counter width is clog2(N_CH). Wrap is never reached because EMIT is forced at N_CH-1.
- No arithmetic on data; words pass bit-exact.

Optional Feature:
- Macro: ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN.
- With the macro defined:
  - Adds output Special_Out (1 bit), registered and asserted together with Valid_Out.
  - Special_Out is set if any word accepted in the frame had exponent bits [30:23]=8'hFF (Inf/NaN).
  - The sticky flag clears on the first accept of the next frame.
  - Reset value 0.
- Without the macro: the port and logic are absent; the interface is otherwise identical.

Decomposition:
- Shared package fp_pkg:
  - FP32 width constant (DW=32).
  - Exponent field bounds [30:23].
  - FP_POS_ZERO = 32'h0000_0000.
  - State enum {COLLECT, EMIT}.
- One natural sub-module: collector_slot_ctrl. It holds the slot counter, the written-mask, the EMIT decision and Frame_Cnt. The top instantiates it plus the buffer array and output masking.

Test Plan:
- Full frame: N_CH=128, stream words 1.0,2.0,...,128.0 back-to-back:
  - Valid_Out pulses once, 1 cycle after the 128th accept.
  - Data_Out slot k = float(k); Frame_Cnt=1; Ready_Out=0 in that EMIT cycle only.
- Partial flush: 5 words of 32'h3F800000 then Flush:
  - Valid_Out next cycle; slots 1-5 = 32'h3F800000, slots 6-128 = 32'h0.
  - Adder-tree sum = 32'h40A00000 (5.0).
- Flush with empty buffer, and Flush during EMIT: no Valid_Out, Frame_Cnt unchanged.
- Flush coincident with 3rd accept: frame closes with 3 written slots; Valid_Out next cycle.
- Reset mid-frame: rst_n low after 60 words:
  - Outputs zero immediately; no Valid_Out.
  - A following full frame is correct; Frame_Cnt counts from 0.
- With ADDER_INPUT_COLLECTOR_SPECIAL_CHK_EN:
  - One word 32'h7FC00000 in frame 1 -> Special_Out=1 with Valid_Out.
  - A clean frame 2 -> Special_Out=0.
